// File: rtl/tmr_pkg.sv
// Shared types for the input-capture timer: FSM state encoding, edge-select
// encoding and the edge-select decode used by the edge detector.
package tmr_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2
  } cap_state_t;

  typedef enum logic [1:0] {
    EDGE_RISE     = 2'b00,
    EDGE_FALL     = 2'b01,
    EDGE_BOTH     = 2'b10,
    EDGE_RISE_ALT = 2'b11
  } edge_sel_t;

  // The unused 11 code behaves as rising, so it falls into the default arm.
  function automatic logic edge_match(input edge_sel_t sel, input logic rise, input logic fall);
    case (sel)
      EDGE_FALL: return fall;
      EDGE_BOTH: return rise | fall;
      default:   return rise;
    endcase
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Synchronises the asynchronous capture line and produces a one-cycle pulse
// on the selected edge polarity. Runs continuously, independent of the FSM.
module edge_detector
  import tmr_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      capture_in,
  input  edge_sel_t edge_sel,
  output logic      edge_pulse
);

  // [0],[1] form the synchroniser, [2] is the history flop.
  logic [2:0] pipe_reg;
  logic       rise;
  logic       fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_reg <= 3'b000;
    end else begin
      pipe_reg <= {pipe_reg[1:0], capture_in};
    end
  end

  assign rise       = pipe_reg[1] & ~pipe_reg[2];
  assign fall       = ~pipe_reg[1] & pipe_reg[2];
  assign edge_pulse = edge_match(edge_sel, rise, fall);

endmodule

// File: rtl/input_capture.sv
// Input-capture timer: measures cycles between consecutive selected edges of
// capture_in, with single-shot/continuous modes, timeout and overrun flagging.
module input_capture
  import tmr_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             capture_in,
  input  logic             trigger,
  input  logic             halt,
  input  logic             single_shot,
  input  logic [1:0]       edge_sel,
  input  logic [CNT_W-1:0] timeout_value,
  input  logic             capture_ack,
  output logic [CNT_W-1:0] captured_value,
  output logic             capture_valid,
  output logic             overrun,
  output logic             timeout,
  output logic             active,
  output logic [CNT_W-1:0] counter
);

  cap_state_t       state_reg, state_next;
  logic [CNT_W-1:0] counter_reg, counter_next;
  logic [CNT_W-1:0] captured_reg, captured_next;
  logic             valid_reg, valid_next;
  logic             overrun_reg, overrun_next;
  logic             timeout_reg, timeout_next;
  logic             single_shot_reg, single_shot_next;
  edge_sel_t        edge_sel_reg, edge_sel_next;
  logic             edge_pulse;
  logic             capture_evt;
  logic [CNT_W-1:0] counter_inc;

  edge_detector u_edge_detector (
    .clk        (clk),
    .rst        (rst),
    .capture_in (capture_in),
    .edge_sel   (edge_sel_reg),
    .edge_pulse (edge_pulse)
  );

  assign counter_inc = counter_reg + {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      counter_reg     <= '0;
      captured_reg    <= '0;
      valid_reg       <= 1'b0;
      overrun_reg     <= 1'b0;
      timeout_reg     <= 1'b0;
      single_shot_reg <= 1'b1;
      edge_sel_reg    <= EDGE_RISE;
    end else begin
      state_reg       <= state_next;
      counter_reg     <= counter_next;
      captured_reg    <= captured_next;
      valid_reg       <= valid_next;
      overrun_reg     <= overrun_next;
      timeout_reg     <= timeout_next;
      single_shot_reg <= single_shot_next;
      edge_sel_reg    <= edge_sel_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    counter_next     = counter_reg;
    captured_next    = captured_reg;
    valid_next       = valid_reg;
    overrun_next     = overrun_reg;
    timeout_next     = 1'b0;
    single_shot_next = single_shot_reg;
    edge_sel_next    = edge_sel_reg;
    capture_evt      = 1'b0;

    // halt outranks every event, including a simultaneous trigger or edge.
    if (halt) begin
      state_next   = ST_IDLE;
      counter_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          counter_next = '0;
          if (trigger) begin
            state_next       = ST_ARMED;
            single_shot_next = single_shot;
            edge_sel_next    = edge_sel_t'(edge_sel);
            overrun_next     = 1'b0;
          end
        end
        ST_ARMED: begin
          counter_next = '0;
          if (edge_pulse) state_next = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (edge_pulse) begin
            capture_evt  = 1'b1;
            counter_next = '0;
            if (single_shot_reg) state_next = ST_IDLE;
          end else if ((timeout_value != '0) && (counter_inc == timeout_value)) begin
            timeout_next = 1'b1;
            counter_next = '0;
            state_next   = ST_IDLE;
          end else begin
            counter_next = counter_inc;
          end
        end
        default: begin
          state_next   = ST_IDLE;
          counter_next = '0;
        end
      endcase
    end

    // An ack in the capture cycle frees the slot for the new value.
    if (capture_evt) begin
      if (!valid_reg || capture_ack) begin
        captured_next = counter_inc;
        valid_next    = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (capture_ack) begin
      valid_next = 1'b0;
    end
  end

  assign captured_value = captured_reg;
  assign capture_valid  = valid_reg;
  assign overrun        = overrun_reg;
  assign timeout        = timeout_reg;
  assign counter        = counter_reg;
  assign active         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_input_capture.sv
// Directed bench for input_capture: a table of single-shot measurements plus
// hand-written sequences for continuous mode, overrun, timeout, halt and reset.
module tb_input_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        capture_in;
  logic        trigger;
  logic        halt;
  logic        single_shot;
  logic [1:0]  edge_sel;
  logic [31:0] timeout_value;
  logic        capture_ack;
  logic [31:0] captured_value;
  logic        capture_valid;
  logic        overrun;
  logic        timeout;
  logic        active;
  logic [31:0] counter;

  int n_cmp  = 0;
  int n_fail = 0;

  input_capture dut (
    .clk            (clk),
    .rst            (rst),
    .capture_in     (capture_in),
    .trigger        (trigger),
    .halt           (halt),
    .single_shot    (single_shot),
    .edge_sel       (edge_sel),
    .timeout_value  (timeout_value),
    .capture_ack    (capture_ack),
    .captured_value (captured_value),
    .capture_valid  (capture_valid),
    .overrun        (overrun),
    .timeout        (timeout),
    .active         (active),
    .counter        (counter)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic        lvl0;
    int          a;
    int          b;
    logic [31:0] exp_val;
  } vec_t;

  vec_t vecs[6];

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; capture_in = 1'b0; trigger = 1'b0; halt = 1'b0;
    single_shot = 1'b1; edge_sel = 2'b00; timeout_value = 32'd0; capture_ack = 1'b0;
    step(2);
    rst = 1'b0;
    step(4);
  endtask

  task automatic arm(input logic [1:0] sel, input logic ss);
    edge_sel = sel; single_shot = ss; trigger = 1'b1;
    step(1);
    trigger = 1'b0;
    step(3);
  endtask

  // One rising edge now, held high 3 cycles, next drive point n cycles later.
  task automatic rise_gap(input int n);
    capture_in = 1'b1;
    step(3);
    capture_in = 1'b0;
    step(n - 3);
  endtask

  task automatic wait_counter(input string name, input logic [31:0] target, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      step(1);
      if (counter == target) ok = 1;
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{2'b00, 1'b0, 20, 30, 32'd50};
    vecs[1] = '{2'b01, 1'b1,  7,  5, 32'd12};
    vecs[2] = '{2'b10, 1'b0,  9,  4, 32'd9};
    vecs[3] = '{2'b10, 1'b1,  3, 11, 32'd3};
    vecs[4] = '{2'b11, 1'b0,  2,  2, 32'd4};
    vecs[5] = '{2'b00, 1'b0,  1,  1, 32'd2};

    // Reset state
    do_reset();
    check("rst_captured", captured_value, 32'd0);
    check("rst_valid", {31'd0, capture_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_counter", counter, 32'd0);
    $display("reset: captured=%0d valid=%0d active=%0d", captured_value, capture_valid, active);

    // Table: single-shot measurements, three transitions at 0, a, a+b
    for (int v = 0; v < 6; v++) begin
      do_reset();
      capture_in = vecs[v].lvl0;
      step(5);
      arm(vecs[v].sel, 1'b1);
      capture_in = ~capture_in; step(vecs[v].a);
      capture_in = ~capture_in; step(vecs[v].b);
      capture_in = ~capture_in; step(6);
      check($sformatf("vec%0d_value", v), captured_value, vecs[v].exp_val);
      check($sformatf("vec%0d_valid", v), {31'd0, capture_valid}, 32'd1);
      check($sformatf("vec%0d_active", v), {31'd0, active}, 32'd0);
      $display("vec %0d: sel=%b captured=%0d expected=%0d", v, vecs[v].sel, captured_value, vecs[v].exp_val);
    end

    // Both edges, continuous, 20 high / 30 low, ack every capture
    begin
      logic [31:0] got[$];
      do_reset();
      arm(2'b10, 1'b0);
      for (int c = 0; c < 220; c++) begin
        capture_in  = ((c % 50) < 20);
        capture_ack = 1'b0;
        if (capture_valid) begin
          got.push_back(captured_value);
          capture_ack = 1'b1;
        end
        step(1);
      end
      capture_ack = 1'b0;
      check("sq_count", got.size(), 32'd8);
      for (int i = 0; i < got.size() && i < 8; i++)
        check($sformatf("sq_cap%0d", i), got[i], (i % 2 == 0) ? 32'd20 : 32'd30);
      check("sq_overrun", {31'd0, overrun}, 32'd0);
      $display("square: %0d captures, overrun=%0d", got.size(), overrun);
    end

    // Continuous, never acked: first value held, overrun, cleared by retrigger
    do_reset();
    arm(2'b00, 1'b0);
    rise_gap(12); rise_gap(8); rise_gap(15);
    capture_in = 1'b1; step(3); capture_in = 1'b0; step(5);
    check("ovr_value", captured_value, 32'd12);
    check("ovr_valid", {31'd0, capture_valid}, 32'd1);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    halt = 1'b1; step(1); halt = 1'b0;
    trigger = 1'b1; step(1); trigger = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    check("ovr_rearmed", {31'd0, active}, 32'd1);
    $display("overrun: captured=%0d overrun=%0d after retrigger", captured_value, overrun);

    // Timeout 100 cycles after MEASURE entry
    begin
      int n = 0;
      bit seen = 0;
      do_reset();
      timeout_value = 32'd100;
      arm(2'b00, 1'b1);
      capture_in = 1'b1;
      wait_counter("to_entry", 32'd1, 50);
      for (int i = 0; i < 200 && !seen; i++) begin
        step(1);
        n++;
        if (timeout) seen = 1;
      end
      check("to_seen", {31'd0, seen}, 32'd1);
      check("to_delay", n, 32'd99);
      check("to_active", {31'd0, active}, 32'd0);
      check("to_counter", counter, 32'd0);
      step(1);
      check("to_onepulse", {31'd0, timeout}, 32'd0);
      $display("timeout: pulse %0d cycles after counter=1", n);
    end

    // Edge coinciding with expiry: capture wins, no timeout
    begin
      bit seen = 0;
      do_reset();
      timeout_value = 32'd100;
      arm(2'b00, 1'b1);
      capture_in = 1'b1;
      for (int i = 0; i < 108; i++) begin
        if (i == 3) capture_in = 1'b0;
        if (i == 100) capture_in = 1'b1;
        step(1);
        if (timeout) seen = 1;
      end
      check("tie_value", captured_value, 32'd100);
      check("tie_valid", {31'd0, capture_valid}, 32'd1);
      check("tie_no_timeout", {31'd0, seen}, 32'd0);
      $display("edge/timeout tie: captured=%0d timeout_seen=%0d", captured_value, seen);
    end

    // halt at counter=37 keeps the pending result
    do_reset();
    arm(2'b00, 1'b0);
    rise_gap(10);
    capture_in = 1'b1;
    wait_counter("halt_reach37", 32'd37, 100);
    halt = 1'b1; step(1); halt = 1'b0;
    check("halt_counter", counter, 32'd0);
    check("halt_active", {31'd0, active}, 32'd0);
    check("halt_valid", {31'd0, capture_valid}, 32'd1);
    check("halt_value", captured_value, 32'd10);
    $display("halt: counter=%0d valid=%0d captured=%0d", counter, capture_valid, captured_value);

    // rst at counter=37 discards everything
    capture_in = 1'b0; step(4);
    arm(2'b00, 1'b0);
    rise_gap(10);
    capture_in = 1'b1;
    wait_counter("rst_reach37", 32'd37, 100);
    rst = 1'b1; step(1); rst = 1'b0;
    check("midrst_counter", counter, 32'd0);
    check("midrst_active", {31'd0, active}, 32'd0);
    check("midrst_valid", {31'd0, capture_valid}, 32'd0);
    check("midrst_value", captured_value, 32'd0);
    $display("mid reset: counter=%0d valid=%0d", counter, capture_valid);

    // trigger together with halt stays idle
    trigger = 1'b1; halt = 1'b1; step(1); trigger = 1'b0; halt = 1'b0;
    check("trig_halt_idle", {31'd0, active}, 32'd0);

    // Toggling while idle leaves no stale edge after arming
    do_reset();
    capture_in = 1'b1; step(2);
    capture_in = 1'b0; step(2);
    capture_in = 1'b1; step(2);
    capture_in = 1'b0; step(6);
    arm(2'b00, 1'b1);
    step(10);
    check("stale_armed", {31'd0, active}, 32'd1);
    check("stale_counter", counter, 32'd0);
    check("stale_valid", {31'd0, capture_valid}, 32'd0);
    rise_gap(15);
    capture_in = 1'b1; step(6);
    check("stale_value", captured_value, 32'd15);
    check("stale_done", {31'd0, active}, 32'd0);
    $display("idle toggles: captured=%0d", captured_value);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/input_capture.md
INPUT_CAPTURE -- requirements
Module: input_capture

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 capture_in  input  1  external, asynchronous event line to be measured.
REQ-004 trigger  input  1  one-cycle start pulse; arms the unit.
REQ-005 halt  input  1  stop request; returns unit to idle.
REQ-006 single_shot  input  1  sampled with trigger; 1 = one capture then idle, 0 = continuous.
REQ-007 edge_sel  input  2  sampled with trigger; 00 rising, 01 falling, 10 both, 11 rising.
REQ-008 timeout_value  input  32  measurement timeout in cycles; 0 disables timeout.
REQ-009 capture_ack  input  1  consumer acknowledge of captured_value.
REQ-010 captured_value  output  32  cycles between two consecutive selected edges.
REQ-011 capture_valid  output  1  captured_value holds an unacknowledged result.
REQ-012 overrun  output  1  sticky; a capture was lost while capture_valid was high.
REQ-013 timeout  output  1  one-cycle pulse on timeout expiry.
REQ-014 active  output  1  high in ARMED or MEASURE.
REQ-015 counter  output  32  running cycle count in MEASURE.

Function
REQ-016 capture_in SHALL pass a 2-flop synchronizer plus one history flop; edge pulse asserted 3 cycles after the input change, identical latency for both polarities.
REQ-017 The synchronizer SHALL run in every state, so no stale edge is detected on arming.
REQ-018 FSM states SHALL be IDLE, ARMED, MEASURE.
REQ-019 IDLE: trigger -> ARMED; single_shot and edge_sel latched; overrun cleared; counter 0.
REQ-020 ARMED: selected edge -> MEASURE with counter 0 next cycle; no capture produced.
REQ-021 MEASURE: counter SHALL increment by 1 per cycle, wrapping 0xFFFFFFFF -> 0.
REQ-022 MEASURE on selected edge: captured_value <= counter+1, counter <= 0; edges N cycles apart yield N.
REQ-023 After a capture, single-shot SHALL go IDLE; continuous SHALL stay MEASURE.
REQ-024 MEASURE, no edge, timeout_value!=0 and counter+1 == timeout_value: timeout pulse, counter 0, state IDLE.
REQ-025 Edge and timeout in the same cycle: edge SHALL win; no timeout pulse.
REQ-026 halt SHALL have priority over all events: any state -> IDLE, counter 0 next cycle; capture_valid and captured_value untouched.
REQ-027 trigger outside IDLE SHALL be ignored; trigger and halt together SHALL yield IDLE.
REQ-028 capture_valid SHALL set on capture and clear on capture_ack when no capture occurs in that cycle.
REQ-029 Capture while capture_valid=1 and capture_ack=0: captured_value kept, overrun set.
REQ-030 Capture with capture_ack=1 in the same cycle: new value stored, capture_valid stays 1, no overrun.
REQ-031 All outputs SHALL be registered, except active, which is decoded from state.

Reset
REQ-032 rst SHALL set state IDLE, counter 0, captured_value 0, capture_valid 0, overrun 0, timeout 0, synchronizer flops 0, latched mode single-shot and rising.
REQ-033 rst mid-measurement SHALL discard any in-progress count; no capture or timeout is emitted for it.

Structure
REQ-034 Package tmr_pkg SHALL hold the capture state enum and the edge_sel encoding typedef.
REQ-035 Sub-module edge_detector SHALL hold the synchronizer, history flop and edge_sel decode, outputting a single edge pulse.

Verification
REQ-036 Rising mode, single-shot, capture_in rises at cycles 10 and 60 -> captured_value=50, capture_valid=1, state IDLE, active=0.
REQ-037 Both-edges mode, continuous, 20-cycle high / 30-cycle low square wave -> captures alternate 20, 30; ack each capture -> overrun stays 0.
REQ-038 Continuous, never ack, three captures -> first value held, overrun=1, retrigger after halt -> overrun=0.
REQ-039 timeout_value=100, one edge then none -> timeout pulse exactly 100 cycles after MEASURE entry, state IDLE; edge and expiry in the same cycle -> capture, no timeout.
REQ-040 halt and rst asserted mid-MEASURE at counter=37 -> counter=0, IDLE next cycle; rst also clears capture_valid, while halt leaves it unchanged.
REQ-041 capture_in toggled while IDLE, then trigger -> no capture until an edge occurs after arming.
